mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 21 ++
 rtl/mem_access_unit.sv | 170 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM stage and the memory system.
// The master issues requests; the slave answers with a single-cycle bus_ack.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage: turns load/store ops into big-endian bus transfers and stalls the pipeline
// until the bus acknowledges. Non-memory ops pass straight through to MEM/WB.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  mem_access_unit_if.master bus,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic        misalign
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [31:0] rdata_q;
  logic        is_load, is_store, is_byte, is_half, is_word, is_signed, is_mem;
  logic        misaligned, req;
  logic [1:0]  off;
  logic [3:0]  lane_sel;
  logic [31:0] store_data;

  assign off = mem_mem_addr[1:0];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    is_signed = 1'b0;
    case (mem_aluop)
      EXE_LB_OP:  begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      EXE_LBU_OP: begin is_load  = 1'b1; is_byte = 1'b1; end
      EXE_LH_OP:  begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      EXE_LHU_OP: begin is_load  = 1'b1; is_half = 1'b1; end
      EXE_LW_OP:  begin is_load  = 1'b1; is_word = 1'b1; end
      EXE_SB_OP:  begin is_store = 1'b1; is_byte = 1'b1; end
      EXE_SH_OP:  begin is_store = 1'b1; is_half = 1'b1; end
      EXE_SW_OP:  begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign misaligned = (is_half & off[0]) | (is_word & (off != 2'b00));

  // Big-endian lanes: address offset 0 is the most significant byte.
  always_comb begin
    lane_sel   = 4'b0000;
    store_data = mem_reg2;
    if (is_byte) begin
      lane_sel   = 4'b1000 >> off;
      store_data = {4{mem_reg2[7:0]}};
    end else if (is_half) begin
      lane_sel   = off[1] ? 4'b0011 : 4'b1100;
      store_data = {2{mem_reg2[15:0]}};
    end else if (is_word) begin
      lane_sel   = 4'b1111;
    end
  end

  function automatic logic [31:0] load_lane(input logic [31:0] word, input logic [1:0] o,
                                            input logic byte_op, input logic half_op,
                                            input logic sign_op);
    logic [7:0]  b;
    logic [15:0] h;
    case (o)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = o[1] ? word[15:0] : word[31:16];
    if (byte_op)      return {{24{sign_op & b[7]}}, b};
    else if (half_op) return {{16{sign_op & h[15]}}, h};
    else              return word;
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state   <= IDLE;
      rdata_q <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == BUSY && bus.bus_ack) rdata_q <= bus.bus_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    stallreq  = 1'b0;
    misalign  = 1'b0;
    wb_wd     = mem_wd;
    wb_wreg   = mem_wreg;
    wb_wdata  = mem_wdata;
    if (is_mem) begin
      wb_wreg  = 1'b0;
      wb_wdata = 32'h0;
    end
    case (state)
      IDLE: begin
        if (is_mem) begin
          if (misaligned) begin
            misalign = 1'b1;
          end else begin
            req       = 1'b1;
            stallreq  = 1'b1;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        req = 1'b1;
        if (bus.bus_ack) begin
          state_nxt = DONE;
          if (is_load) begin
            wb_wreg  = mem_wreg;
            wb_wdata = load_lane(bus.bus_rdata, off, is_byte, is_half, is_signed);
          end
        end else begin
          stallreq = 1'b1;
        end
      end
      DONE: begin
        // The op retired on the ack; present the captured data, never reissue.
        state_nxt = IDLE;
        if (is_load && !misaligned) begin
          wb_wreg  = mem_wreg;
          wb_wdata = load_lane(rdata_q, off, is_byte, is_half, is_signed);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      req      = 1'b0;
      stallreq = 1'b0;
      misalign = 1'b0;
      wb_wreg  = 1'b0;
    end
  end

  assign bus.bus_req   = req;
  assign bus.bus_we    = req & is_store;
  assign bus.bus_sel   = req ? lane_sel : 4'b0000;
  assign bus.bus_addr  = {mem_mem_addr[31:2], 2'b00};
  assign bus.bus_wdata = store_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model checked every cycle,
// plus literal expectations for the reference scenarios.
module tb_mem_access_unit;

  localparam logic [7:0] OP_LB   = 8'hE0;
  localparam logic [7:0] OP_LBU  = 8'hE4;
  localparam logic [7:0] OP_LH   = 8'hE1;
  localparam logic [7:0] OP_LHU  = 8'hE5;
  localparam logic [7:0] OP_LW   = 8'hE3;
  localparam logic [7:0] OP_SB   = 8'hE8;
  localparam logic [7:0] OP_SH   = 8'hE9;
  localparam logic [7:0] OP_SW   = 8'hEB;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_NOP  = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq;
  logic        misalign;

  mem_access_unit_if bus_if ();

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .bus          (bus_if),
    .wb_wd        (wb_wd),
    .wb_wreg      (wb_wreg),
    .wb_wdata     (wb_wdata),
    .stallreq     (stallreq),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_out;   // a request is on the bus awaiting ack
  bit          m_ret;   // an op was acknowledged last cycle
  logic [31:0] m_cap;

  function automatic void op_info(input logic [7:0] op, output int nb, output bit st, output bit sg);
    nb = 0; st = 0; sg = 0;
    case (op)
      OP_LB:  begin nb = 1; sg = 1; end
      OP_LBU: nb = 1;
      OP_LH:  begin nb = 2; sg = 1; end
      OP_LHU: nb = 2;
      OP_LW:  nb = 4;
      OP_SB:  begin nb = 1; st = 1; end
      OP_SH:  begin nb = 2; st = 1; end
      OP_SW:  begin nb = 4; st = 1; end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] lane_val(input logic [31:0] w, input int off, input int nb, input bit sg);
    logic [31:0] v;
    if (nb == 4) return w;
    v = w >> (8 * (4 - nb - off));
    if (nb == 1) begin
      v &= 32'hFF;
      if (sg && v[7]) v |= 32'hFFFF_FF00;
    end else begin
      v &= 32'hFFFF;
      if (sg && v[15]) v |= 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] sel_val(input int off, input int nb);
    int m;
    m = ((1 << nb) - 1) << (4 - nb - off);
    return 4'(m);
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] r, input int nb);
    logic [31:0] unit, v;
    unit = (nb == 4) ? r : (r & ((32'h1 << (8 * nb)) - 32'h1));
    v = 32'h0;
    for (int k = 0; k < 4 / nb; k++) v |= unit << (8 * nb * k);
    return v;
  endfunction

  task automatic compare_cycle();
    int   nb, off;
    bit   st, sg, is_mem, aligned;
    logic e_req, e_stall, e_mis, e_wreg;
    logic [31:0] e_wdata;
    op_info(mem_aluop, nb, st, sg);
    off     = int'(mem_mem_addr[1:0]);
    is_mem  = (nb != 0);
    aligned = is_mem && ((off % nb) == 0);
    e_req = 1'b0; e_stall = 1'b0; e_mis = 1'b0;
    e_wreg  = is_mem ? 1'b0 : mem_wreg;
    e_wdata = is_mem ? 32'h0 : mem_wdata;
    if (rst) begin
      e_wreg = 1'b0;
      m_out = 0; m_ret = 0; m_cap = 32'h0;
    end else if (m_out) begin
      e_req = 1'b1;
      if (bus_if.bus_ack) begin
        if (is_mem && !st) begin
          e_wreg  = mem_wreg;
          e_wdata = lane_val(bus_if.bus_rdata, off, nb, sg);
        end
        m_cap = bus_if.bus_rdata;
        m_out = 0;
        m_ret = 1;
      end else begin
        e_stall = 1'b1;
      end
    end else if (m_ret) begin
      if (is_mem && !st && aligned) begin
        e_wreg  = mem_wreg;
        e_wdata = lane_val(m_cap, off, nb, sg);
      end
      m_ret = 0;
    end else if (is_mem) begin
      if (!aligned) e_mis = 1'b1;
      else begin
        e_req = 1'b1; e_stall = 1'b1; m_out = 1;
      end
    end
    check("m_bus_req",  bus_if.bus_req, e_req);
    check("m_bus_we",   bus_if.bus_we,  e_req & st);
    check("m_bus_sel",  bus_if.bus_sel, e_req ? sel_val(off, nb) : 4'b0000);
    check("m_stallreq", stallreq, e_stall);
    check("m_misalign", misalign, e_mis);
    check("m_wb_wreg",  wb_wreg,  e_wreg);
    if (!rst) begin
      check("m_wb_wd",    wb_wd,    mem_wd);
      check("m_wb_wdata", wb_wdata, e_wdata);
    end
    if (e_req) check("m_bus_addr", bus_if.bus_addr, mem_mem_addr & 32'hFFFF_FFFC);
    if (e_req && st) check("m_bus_wdata", bus_if.bus_wdata, store_val(mem_reg2, nb));
  endtask

  always @(negedge clk) compare_cycle();

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
    mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
  endtask

  // Issue cycle, `waits` wait cycles, ack cycle, retire cycle; then back to a NOP.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] rdata, input int waits,
                        output int stall_n, output int req_n,
                        output logic [31:0] ack_wdata, output logic [31:0] done_wdata,
                        output logic [31:0] wd_seen, output logic ack_wreg,
                        output logic we_seen, output logic [3:0] sel_seen);
    drive(op, addr, reg2, 5'd9, 1'b1, 32'h0BAD_0BAD);
    stall_n = 0; req_n = 0;
    for (int c = 0; c <= waits + 2; c++) begin
      bus_if.bus_ack   = (c == waits + 1);
      bus_if.bus_rdata = (c == waits + 1) ? rdata : 32'h5A5A_5A5A;
      @(negedge clk);
      stall_n += int'(stallreq);
      req_n   += int'(bus_if.bus_req);
      if (c == 0) begin
        sel_seen = bus_if.bus_sel; we_seen = bus_if.bus_we; wd_seen = bus_if.bus_wdata;
      end
      if (c == waits + 1) begin
        ack_wdata = wb_wdata; ack_wreg = wb_wreg;
      end
      if (c == waits + 2) done_wdata = wb_wdata;
      tick();
    end
    bus_if.bus_ack = 1'b0;
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
  endtask

  initial begin
    int          sn, rn;
    logic [31:0] aw, dw, wd;
    logic        awr, we;
    logic [3:0]  sel;

    rst = 1'b1;
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h1111_1111;
    drive(OP_SW, 32'h100, 32'hFFFF_FFFF, 5'd1, 1'b1, 32'h1);
    tick();
    @(negedge clk);
    check("rst_bus_req",  bus_if.bus_req, 1'b0);
    check("rst_bus_we",   bus_if.bus_we, 1'b0);
    check("rst_bus_sel",  bus_if.bus_sel, 4'b0000);
    check("rst_stallreq", stallreq, 1'b0);
    check("rst_wb_wreg",  wb_wreg, 1'b0);
    tick();
    rst = 1'b0;
    bus_if.bus_ack = 1'b0;
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    tick();

    run_op(OP_LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, sn, rn, aw, dw, wd, awr, we, sel);
    check("lw_stall_cycles", sn, 3);
    check("lw_req_cycles",   rn, 4);
    check("lw_ack_wdata",    aw, 32'hDEAD_BEEF);
    check("lw_ack_wreg",     awr, 1'b1);
    check("lw_done_wdata",   dw, 32'hDEAD_BEEF);
    check("lw_sel",          sel, 4'b1111);

    run_op(OP_LB, 32'h103, 32'h0, 32'h0000_00F0, 0, sn, rn, aw, dw, wd, awr, we, sel);
    check("lb_sel",       sel, 4'b0001);
    check("lb_ack_wdata", aw, 32'hFFFF_FFF0);
    check("lb_stall",     sn, 1);

    run_op(OP_LBU, 32'h103, 32'h0, 32'h0000_00F0, 0, sn, rn, aw, dw, wd, awr, we, sel);
    check("lbu_ack_wdata", aw, 32'h0000_00F0);

    run_op(OP_SH, 32'h202, 32'h1234_ABCD, 32'h0, 0, sn, rn, aw, dw, wd, awr, we, sel);
    check("sh_we",         we, 1'b1);
    check("sh_sel",        sel, 4'b0011);
    check("sh_wdata",      wd, 32'hABCD_ABCD);
    check("sh_wreg",       awr, 1'b0);
    check("sh_req_cycles", rn, 2);

    run_op(OP_LH, 32'h102, 32'h0, 32'h1234_8001, 1, sn, rn, aw, dw, wd, awr, we, sel);
    check("lh_ack_wdata",  aw, 32'hFFFF_8001);
    check("lh_done_wdata", dw, 32'hFFFF_8001);
    check("lh_stall",      sn, 2);

    run_op(OP_LHU, 32'h100, 32'h0, 32'h8234_8001, 0, sn, rn, aw, dw, wd, awr, we, sel);
    check("lhu_ack_wdata", aw, 32'h0000_8234);

    run_op(OP_SB, 32'h101, 32'h0000_00CD, 32'h0, 0, sn, rn, aw, dw, wd, awr, we, sel);
    check("sb_sel",   sel, 4'b0100);
    check("sb_wdata", wd, 32'hCDCD_CDCD);

    run_op(OP_SW, 32'h104, 32'hCAFE_BABE, 32'h0, 3, sn, rn, aw, dw, wd, awr, we, sel);
    check("sw_sel",   sel, 4'b1111);
    check("sw_wdata", wd, 32'hCAFE_BABE);
    check("sw_stall", sn, 4);

    drive(OP_LW, 32'h101, 32'h0, 5'd4, 1'b1, 32'h0);
    @(negedge clk);
    check("mis_lw_misalign", misalign, 1'b1);
    check("mis_lw_req",      bus_if.bus_req, 1'b0);
    check("mis_lw_stall",    stallreq, 1'b0);
    check("mis_lw_wreg",     wb_wreg, 1'b0);
    tick();
    drive(OP_SH, 32'h203, 32'h0, 5'd4, 1'b1, 32'h0);
    @(negedge clk);
    check("mis_sh_misalign", misalign, 1'b1);
    tick();
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(negedge clk);
    check("mis_clear", misalign, 1'b0);
    tick();

    drive(OP_LW, 32'h300, 32'h0, 5'd6, 1'b1, 32'h0);
    @(negedge clk);
    tick();
    @(negedge clk);
    check("rb_busy_stall", stallreq, 1'b1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rb_rst_req", bus_if.bus_req, 1'b0);
    tick();
    rst = 1'b0;
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("rb_late_ack_req",  bus_if.bus_req, 1'b0);
    check("rb_late_ack_wreg", wb_wreg, 1'b0);
    tick();
    bus_if.bus_ack = 1'b0;
    run_op(OP_LBU, 32'h100, 32'h0, 32'h7F00_0000, 0, sn, rn, aw, dw, wd, awr, we, sel);
    check("rb_fresh_stall", sn, 1);
    check("rb_fresh_wdata", aw, 32'h0000_007F);

    drive(OP_ADDU, 32'h40, 32'h0, 5'd5, 1'b1, 32'h7);
    @(negedge clk);
    check("addu_wd",    wb_wd, 5'd5);
    check("addu_wdata", wb_wdata, 32'h7);
    check("addu_wreg",  wb_wreg, 1'b1);
    check("addu_req",   bus_if.bus_req, 1'b0);
    tick();
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
